// File: rtl/rt_frame_scheduler_pkg.sv
// Shared types and constants for the ray-trace frame scheduler.
//   World_s : scene description (one sphere) handed to the ray-trace core
//   Pixel_s : primary-ray direction for one pixel (x, y signed; z = focal depth)
//   sched_state_e : scheduler FSM states
package rt_frame_scheduler_pkg;

  localparam int H_RES_DEFAULT    = 320;
  localparam int V_RES_DEFAULT    = 240;
  localparam int CORE_LAT_DEFAULT = 5;
  localparam int FB_ADDR_W        = 17;
  localparam int COORD_W          = 10;

  typedef struct packed {
    logic signed [7:0] center_x;
    logic signed [7:0] center_y;
    logic signed [7:0] center_z;
    logic [7:0]        radius;
  } World_s;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic [4:0]                z;
  } Pixel_s;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rt_result_fifo.sv
// Synchronous result buffer between the ray-trace core and the framebuffer
// write channel. Head entry is presented combinationally and stays put until
// popped; push and pop may happen together.
// Ports:
//   clk, rst      : clock, async active-high reset (clears pointers/count)
//   push/push_data: enqueue one entry
//   pop           : dequeue the head entry
//   head_valid    : buffer not empty
//   head_data     : head entry (zero while empty)
//   count         : current number of entries
module rt_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/rt_frame_scheduler.sv
// Frame scheduler for a fixed-latency ray-trace core. Walks the frame in
// raster order, feeds one primary ray per cycle to the core, tracks each ray
// through the core's latency, and turns the core's verdict into framebuffer
// writes through a small result buffer. Issue is throttled so every ray in
// flight is guaranteed a buffer slot, which lets the core run unstalled.
// Ports:
//   clk, rst            : clock, async active-high reset
//   start               : begin a frame (honoured only when idle)
//   focal_z, world_in   : ray depth and scene, captured at frame start
//   busy, frame_done    : frame in progress / one-cycle end-of-frame pulse
//   world, pixel        : latched scene and current ray to the core
//   less_than_zero      : core verdict (discriminant negative => miss)
//   wr_valid/wr_ready   : framebuffer write handshake
//   wr_addr, wr_hit     : pixel address and hit flag of the head write
module rt_frame_scheduler
  import rt_frame_scheduler_pkg::*;
#(
  parameter int H_RES      = H_RES_DEFAULT,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter int CORE_LAT   = CORE_LAT_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           focal_z,
  input  World_s               world_in,
  output logic                 busy,
  output logic                 frame_done,
  output World_s               world,
  output Pixel_s               pixel,
  input  logic                 less_than_zero,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic                 wr_hit
);

  localparam int COL_W   = $clog2(H_RES);
  localparam int ROW_W   = $clog2(V_RES);
  localparam int ENTRY_W = FB_ADDR_W + 1;
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W    = $clog2(CORE_LAT + 2);

  sched_state_e         state;
  sched_state_e         state_next;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [FB_ADDR_W-1:0] issue_addr;
  logic [4:0]           focal_lat;
  logic                 pix_valid;
  logic [FB_ADDR_W-1:0] pix_addr;
  logic [CORE_LAT-1:0]  sr_valid;
  logic [FB_ADDR_W-1:0] sr_addr [CORE_LAT];
  logic [IF_W-1:0]      inflight;
  logic [FCNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]   head_data;
  logic                 start_frame;
  logic                 can_issue;
  logic                 issue;
  logic                 last_pixel;
  logic                 result_push;
  logic                 result_pop;

  // Every ray already issued must still find room in the buffer, so count
  // both buffered and in-flight results before letting another one go.
  assign can_issue   = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign issue       = (state == ISSUE) && can_issue;
  assign start_frame = (state == IDLE) && start;
  assign last_pixel  = (issue_addr == FB_ADDR_W'(H_RES * V_RES - 1));
  assign result_push = sr_valid[CORE_LAT-1];
  assign result_pop  = wr_valid && wr_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs. frame_done rises in the cycle that both the
  // core pipeline and the buffer are empty, which is the cycle after the last pop.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (issue && last_pixel) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((inflight == '0) && (fifo_count == '0)) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Raster scan and ray generation. The scene and focal depth are frozen at
  // frame start; the ray register only moves on an issue so a stalled ray
  // stays on the core's input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      issue_addr <= '0;
      focal_lat  <= '0;
      world      <= '0;
      pixel      <= '0;
    end else if (start_frame) begin
      col        <= '0;
      row        <= '0;
      issue_addr <= '0;
      focal_lat  <= focal_z;
      world      <= world_in;
    end else if (issue) begin
      pixel.x    <= COORD_W'(col) - COORD_W'(H_RES / 2);
      pixel.y    <= COORD_W'(V_RES / 2) - COORD_W'(row);
      pixel.z    <= focal_lat;
      issue_addr <= issue_addr + FB_ADDR_W'(1);
      if (col == COL_W'(H_RES - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Valid tracking through the core. pix_valid marks the ray register itself;
  // the shift register then mirrors the core's CORE_LAT stages so a valid
  // leaving the last stage lines up with that ray's verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      sr_valid  <= '0;
      inflight  <= '0;
    end else begin
      pix_valid   <= issue;
      sr_valid[0] <= pix_valid;
      for (int i = 1; i < CORE_LAT; i++) begin
        sr_valid[i] <= sr_valid[i-1];
      end
      inflight <= inflight + IF_W'(issue) - IF_W'(result_push);
    end
  end

  // Addresses ride alongside the valids; they need no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      pix_addr <= issue_addr;
    end
    sr_addr[0] <= pix_addr;
    for (int i = 1; i < CORE_LAT; i++) begin
      sr_addr[i] <= sr_addr[i-1];
    end
  end

  rt_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (FCNT_W)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (result_push),
    .push_data  ({sr_addr[CORE_LAT-1], ~less_than_zero}),
    .pop        (result_pop),
    .head_valid (wr_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign wr_addr = head_data[ENTRY_W-1:1];
  assign wr_hit  = head_data[0];

endmodule

// File: doc/rt_frame_scheduler.md
RT_FRAME_SCHEDULER -- requirements
Module: rt_frame_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 320, horizontal pixel count per frame.
REQ-002 SHALL have parameter V_RES, default 240, vertical pixel count per frame.
REQ-003 SHALL have parameter CORE_LAT, default 5, cycles from pixel presented to RayTraceCore until its less_than_zero reflects that pixel.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, result buffer entries; FIFO_DEPTH > CORE_LAT.
REQ-005 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: start in 1, begin a frame; focal_z in 5, ray z component; world_in in World_s, scene for next frame.
REQ-007 SHALL have ports: busy out 1, frame in progress; frame_done out 1, one-cycle end-of-frame pulse.
REQ-008 SHALL have ports: world out World_s, latched scene to core; pixel out Pixel_s, ray to core; less_than_zero in 1, core result.
REQ-009 SHALL have ports: wr_valid out 1, wr_ready in 1, wr_addr out 17, wr_hit out 1; framebuffer write channel.

Function
REQ-010 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start, ISSUE->DRAIN after last pixel issued, DRAIN->IDLE when in-flight count and FIFO both zero.
REQ-011 SHALL, on IDLE->ISSUE, latch world_in into world and focal_z internally; both held constant until return to IDLE.
REQ-012 SHALL ignore start outside IDLE.
REQ-013 SHALL scan raster order: col 0..H_RES-1 inner, row 0..V_RES-1 outer, col wrapping to 0 with row increment.
REQ-014 SHALL drive pixel.x = col - H_RES/2, pixel.y = V_RES/2 - row (two's complement), pixel.z = latched focal_z.
REQ-015 SHALL issue one pixel per cycle only when fifo_count + inflight_count < FIFO_DEPTH; otherwise hold col/row and pixel unchanged (issue stall).
REQ-016 SHALL track issued pixels with a CORE_LAT-deep valid/address shift register advancing every cycle; core is never stalled.
REQ-017 SHALL push {addr, ~less_than_zero} into FIFO when valid emerges from shift register stage CORE_LAT; push never blocked by REQ-015.
REQ-018 SHALL set wr_addr = row*H_RES + col of that pixel (0..H_RES*V_RES-1), wr_hit = 1 when discriminant >= 0.
REQ-019 SHALL present FIFO head as wr_valid/wr_addr/wr_hit; entry removed on wr_valid && wr_ready; wr_addr/wr_hit stable while wr_valid && !wr_ready.
REQ-020 SHALL support simultaneous push and pop in one cycle with count unchanged.
REQ-021 SHALL assert busy in ISSUE and DRAIN, deassert in IDLE.
REQ-022 SHALL pulse frame_done the cycle after final FIFO pop of the frame, concurrent with DRAIN->IDLE.
REQ-023 SHALL write exactly H_RES*V_RES entries per frame, no duplicates, in raster order.
REQ-024 SHALL accept start in the cycle frame_done is high is not required; start takes effect only from IDLE.

Reset
REQ-025 SHALL, on rst, asynchronously enter IDLE, clear col, row, shift register valids, FIFO pointers/count.
REQ-026 SHALL reset outputs: busy 0, frame_done 0, wr_valid 0, wr_addr 0, wr_hit 0, pixel all-zero, world all-zero.
REQ-027 SHALL, on rst mid-frame, discard all in-flight and buffered results; no write after rst deasserts until next start.

Structure
REQ-028 SHALL take World_s, Pixel_s from the shared types package; H_RES, V_RES, CORE_LAT defaults and FB_ADDR_W=17 SHALL be package constants.
REQ-029 SHALL place the result buffer in one sub-module rt_result_fifo (synchronous FIFO, parameter depth/width, count output).

Verification
REQ-030 Bench SHALL use a CORE_LAT-cycle reference model of RayTraceCore.
REQ-031 Reset then start, wr_ready=1 -> 76800 writes, addr 0..76799 in order, frame_done after write 76799, busy low next cycle.
REQ-032 Sphere origin (0,0,40), radius 20, focal_z 16 -> wr_hit=1 at addr 120*320+160, 0 at addr 0.
REQ-033 wr_ready=0 for 50 cycles after start -> exactly FIFO_DEPTH entries buffered, pixel frozen, no lost or duplicated addr after release.
REQ-034 wr_ready toggled randomly 50% -> all 76800 addrs exactly once, wr_addr stable during stalls.
REQ-035 rst asserted at write 1000 -> wr_valid 0 immediately, busy 0; start pulse while busy -> ignored, world unchanged.
